// File: rtl/sh7034_dmac_arb.sv
// SH7034 DMAC channel arbiter and bus sequencer.
// Picks one of four requesting channels by the DMAOR.PR priority mode.
// Requests the bus from the BSC and holds it for one unit (cycle-steal)
// or for back-to-back units (burst).
// Returns a registered one-hot acknowledge for every completed unit.
module sh7034_dmac_arb (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic       DME,
  input  logic       NMIF,
  input  logic       AE,
  input  logic [1:0] PR,
  input  logic [3:0] CH_REQ,
  input  logic [3:0] CH_TM,
  input  logic       BUS_GNT,
  input  logic       XFER_DONE,
  output logic       BUS_REQ,
  output logic [1:0] CH_SEL,
  output logic       CH_ACT,
  output logic [3:0] CH_ACK,
  output logic       ARB_IDLE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       busReq_q, busReq_d;
  logic       chAct_q, chAct_d;
  logic [1:0] chSel_q, chSel_d;
  logic [3:0] chAck_q, chAck_d;
  logic [1:0] rrPtr_q, rrPtr_d;

  logic       en;
  logic [3:0] reqEff;
  logic [1:0] winner;
  logic [1:0] rrIdx;
  logic       selReq;
  logic       burstGo;

  // A set NMIF or AE flag masks every request, exactly like a cleared DME.
  assign en      = DME & ~NMIF & ~AE;
  assign reqEff  = CH_REQ & {4{en}};
  assign selReq  = CH_REQ[chSel_q];
  assign burstGo = CH_TM[chSel_q] & selReq & en;

  // Combinational priority pick over the effective requests.
  always_comb begin
    winner = 2'd0;
    rrIdx  = 2'd0;
    case (PR)
      2'b01: begin
        if (reqEff[1])      winner = 2'd1;
        else if (reqEff[3]) winner = 2'd3;
        else if (reqEff[2]) winner = 2'd2;
        else                winner = 2'd0;
      end
      2'b10: begin
        // Walk from the farthest offset down so the channel nearest RR wins.
        for (int off = 3; off >= 0; off--) begin
          rrIdx = rrPtr_q + off[1:0];
          if (reqEff[rrIdx]) winner = rrIdx;
        end
      end
      default: begin
        if (reqEff[0])      winner = 2'd0;
        else if (reqEff[3]) winner = 2'd3;
        else if (reqEff[2]) winner = 2'd2;
        else                winner = 2'd1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)  state_q <= IDLE;
    else if (CE) state_q <= state_d;
  end

  // Next-state logic. A unit that has started is never abandoned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|reqEff) state_d = REQ;
      REQ: begin
        if (!selReq || !en) state_d = IDLE;
        else if (BUS_GNT)   state_d = XFER;
      end
      XFER: if (XFER_DONE && !burstGo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and of the round-robin pointer.
  always_comb begin
    busReq_d = busReq_q;
    chAct_d  = chAct_q;
    chSel_d  = chSel_q;
    chAck_d  = 4'b0000;
    rrPtr_d  = rrPtr_q;
    case (state_q)
      IDLE: begin
        chAct_d = 1'b0;
        if (|reqEff) begin
          chSel_d  = winner;
          busReq_d = 1'b1;
        end else begin
          busReq_d = 1'b0;
        end
      end
      REQ: begin
        if (!selReq || !en) busReq_d = 1'b0;
        else if (BUS_GNT)   chAct_d  = 1'b1;
      end
      XFER: begin
        if (XFER_DONE) begin
          chAck_d = 4'b0001 << chSel_q;
          if (PR == 2'b10) rrPtr_d = chSel_q + 2'd1;
          if (!burstGo) begin
            busReq_d = 1'b0;
            chAct_d  = 1'b0;
          end
        end
      end
      default: begin
        busReq_d = 1'b0;
        chAct_d  = 1'b0;
      end
    endcase
  end

  // Output and pointer registers; everything advances only on CE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busReq_q <= 1'b0;
      chAct_q  <= 1'b0;
      chSel_q  <= 2'd0;
      chAck_q  <= 4'b0000;
      rrPtr_q  <= 2'd0;
    end else if (CE) begin
      busReq_q <= busReq_d;
      chAct_q  <= chAct_d;
      chSel_q  <= chSel_d;
      chAck_q  <= chAck_d;
      rrPtr_q  <= rrPtr_d;
    end
  end

  assign BUS_REQ  = busReq_q;
  assign CH_ACT   = chAct_q;
  assign CH_SEL   = chSel_q;
  assign CH_ACK   = chAck_q;
  assign ARB_IDLE = (state_q == IDLE);

endmodule

// File: tb/tb_sh7034_dmac_arb.sv
// Scoreboard testbench for sh7034_dmac_arb.
// Each channel is given a number of pending units.
// A reference model predicts the order of acknowledges and pushes it into a queue.
// A monitor pops the queue and compares whenever CH_ACK pulses.
module tb_sh7034_dmac_arb;

  logic       CLK = 1'b0;
  logic       RST_N, CE, DME, NMIF, AE;
  logic [1:0] PR;
  logic [3:0] CH_REQ, CH_TM;
  logic       BUS_GNT, XFER_DONE;
  logic       BUS_REQ;
  logic [1:0] CH_SEL;
  logic       CH_ACT;
  logic [3:0] CH_ACK;
  logic       ARB_IDLE;

  typedef struct {
    int ch;
    bit cont;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   fails  = 0;
  int   cnt[4];
  int   mRr = 0;

  sh7034_dmac_arb dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .DME(DME), .NMIF(NMIF), .AE(AE),
    .PR(PR), .CH_REQ(CH_REQ), .CH_TM(CH_TM), .BUS_GNT(BUS_GNT),
    .XFER_DONE(XFER_DONE), .BUS_REQ(BUS_REQ), .CH_SEL(CH_SEL),
    .CH_ACT(CH_ACT), .CH_ACK(CH_ACK), .ARB_IDLE(ARB_IDLE)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, required, $time);
    end
  endtask

  // Priority order is listed directly from the mode, then scanned for the first requester.
  function automatic int pickWinner(input logic [3:0] mask, input logic [1:0] pr, input int rr);
    int order[4];
    if (pr == 2'b10) begin
      for (int i = 0; i < 4; i++) order[i] = (rr + i) % 4;
    end else if (pr == 2'b01) begin
      order = '{1, 3, 2, 0};
    end else begin
      order = '{0, 3, 2, 1};
    end
    for (int i = 0; i < 4; i++) if (mask[order[i]]) return order[i];
    return 0;
  endfunction

  function automatic logic [3:0] maskOf(input int a, input int b, input int c, input int d);
    return {d > 0, c > 0, b > 0, a > 0};
  endfunction

  // Reference model: consumes the pending-unit counts in grant order.
  task automatic predict();
    int tmp[4];
    int w;
    bit cont;
    tmp = cnt;
    while (tmp[0] + tmp[1] + tmp[2] + tmp[3] > 0) begin
      w = pickWinner(maskOf(tmp[0], tmp[1], tmp[2], tmp[3]), PR, mRr);
      do begin
        tmp[w]--;
        if (PR == 2'b10) mRr = (w + 1) % 4;
        cont = CH_TM[w] && (tmp[w] > 0);
        sbQ.push_back('{w, cont});
      end while (cont);
    end
  endtask

  // Play the request sources and the datapath until every pending unit is done.
  task automatic applyStimulus(input int c0, input int c1, input int c2, input int c3,
                               input bit randGnt);
    int cyc;
    cnt = '{c0, c1, c2, c3};
    predict();
    CH_REQ = maskOf(cnt[0], cnt[1], cnt[2], cnt[3]);
    cyc = 0;
    forever begin
      @(negedge CLK);
      XFER_DONE = 1'b0;
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0 && !CH_ACT && ARB_IDLE) break;
      cyc++;
      if (cyc > 3000) begin
        checkOutput("runTimeout", cyc, 3000);
        break;
      end
      BUS_GNT = randGnt ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (CH_ACT && $urandom_range(0, 3) != 0) begin
        XFER_DONE = 1'b1;
        if (cnt[CH_SEL] > 0) cnt[CH_SEL]--;
        CH_REQ = maskOf(cnt[0], cnt[1], cnt[2], cnt[3]);
      end
    end
    repeat (2) @(negedge CLK);
    checkOutput("sbDrain", sbQ.size(), 0);
    sbQ.delete();
  endtask

  task automatic waitAct(input string name);
    int cyc;
    cyc = 0;
    while (!CH_ACT && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    checkOutput(name, CH_ACT, 1);
  endtask

  task automatic checkReset();
    checkOutput("rstBusReq", BUS_REQ, 0);
    checkOutput("rstChSel", CH_SEL, 0);
    checkOutput("rstChAct", CH_ACT, 0);
    checkOutput("rstChAck", CH_ACK, 0);
    checkOutput("rstIdle", ARB_IDLE, 1);
  endtask

  // Monitor: every acknowledge must match the next predicted unit.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && CH_ACK != 4'b0000) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedAck", CH_ACK, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("ackOneHot", CH_ACK, 1 << e.ch);
        checkOutput("ackSel", CH_SEL, e.ch);
        checkOutput("busReqAfterAck", BUS_REQ, e.cont);
        checkOutput("actAfterAck", CH_ACT, e.cont);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int r0, r1, r2, r3;
    RST_N = 1'b0; CE = 1'b1; DME = 1'b1; NMIF = 1'b0; AE = 1'b0;
    PR = 2'b00; CH_REQ = 4'b0000; CH_TM = 4'b0000;
    BUS_GNT = 1'b0; XFER_DONE = 1'b0;
    repeat (2) @(negedge CLK);
    checkReset();
    mRr = 0;
    RST_N = 1'b1;
    @(negedge CLK);

    // Fixed priority 0>3>2>1 with cycle-steal units.
    PR = 2'b00; CH_TM = 4'b0000;
    applyStimulus(0, 1, 1, 1, 1'b0);

    // Round robin over all four channels, two laps.
    PR = 2'b10;
    applyStimulus(2, 2, 2, 2, 1'b0);

    // Burst on CH0 must not be preempted by CH3.
    PR = 2'b00; CH_TM = 4'b0001;
    applyStimulus(4, 0, 0, 2, 1'b0);

    // Withdrawn request before grant.
    CH_TM = 4'b0000; BUS_GNT = 1'b0;
    CH_REQ = 4'b0010;
    @(negedge CLK);
    checkOutput("wdBusReqUp", BUS_REQ, 1);
    checkOutput("wdNotIdle", ARB_IDLE, 0);
    CH_REQ = 4'b0000;
    @(negedge CLK);
    checkOutput("wdBusReqDown", BUS_REQ, 0);
    checkOutput("wdIdle", ARB_IDLE, 1);
    checkOutput("wdNoAct", CH_ACT, 0);

    // NMI halt while CH2 is transferring.
    BUS_GNT = 1'b1; CH_REQ = 4'b0100;
    waitAct("haltActWait");
    checkOutput("haltSel", CH_SEL, 2);
    NMIF = 1'b1;
    sbQ.push_back('{2, 1'b0});
    XFER_DONE = 1'b1;
    @(negedge CLK);
    XFER_DONE = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("haltBusReq", BUS_REQ, 0);
    checkOutput("haltIdle", ARB_IDLE, 1);
    NMIF = 1'b0;
    @(negedge CLK);
    checkOutput("resumeBusReq", BUS_REQ, 1);
    applyStimulus(0, 0, 1, 0, 1'b0);

    // Randomized modes, burst flags, unit counts and grant delays.
    repeat (25) begin
      PR = 2'($urandom_range(0, 3));
      CH_TM = 4'($urandom_range(0, 15));
      r0 = $urandom_range(0, 3); r1 = $urandom_range(0, 3);
      r2 = $urandom_range(0, 3); r3 = $urandom_range(0, 3);
      if (r0 + r1 + r2 + r3 == 0) r1 = 1;
      applyStimulus(r0, r1, r2, r3, 1'b1);
    end

    // Leave the round-robin pointer at 3.
    PR = 2'b10; CH_TM = 4'b0000;
    applyStimulus(0, 0, 1, 0, 1'b0);

    // Asynchronous reset in XFER with CE low.
    PR = 2'b00; BUS_GNT = 1'b1; CH_REQ = 4'b0001;
    waitAct("rstActWait");
    CE = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    checkReset();
    mRr = 0;
    @(negedge CLK);
    RST_N = 1'b1; CE = 1'b1; PR = 2'b10; CH_REQ = 4'b0000;
    applyStimulus(1, 1, 1, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sh7034_dmac_arb.md
Name: sh7034_dmac_arb

Overview:
- Channel arbiter and bus sequencer for the SH7034 four-channel DMAC.
- Takes per-channel transfer requests and the DMAOR control bits (DME, NMIF, AE, PR), and selects one channel according to the PR priority mode.
- Requests the bus from the BSC, holds it for one unit (cycle-steal) or for consecutive units (burst), and returns a per-channel acknowledge for each completed unit.
- Sits between the DMAC register file and the DMAC address/data datapath.

Parameters:
- none

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE  in  1  clock enable; all state advances only on CLK rising edge with CE=1
- DME  in  1  DMAOR.DME, master enable
- NMIF  in  1  DMAOR.NMIF, NMI halt flag
- AE  in  1  DMAOR.AE, address error halt flag
- PR  in  2  DMAOR.PR, priority mode
- CH_REQ  in  4  per-channel request; bit n = CHCRn.DE & ~CHCRn.TE & request source active
- CH_TM  in  4  per-channel CHCRn.TM (1 = burst, 0 = cycle-steal)
- BUS_GNT  in  1  BSC bus grant
- XFER_DONE  in  1  datapath has completed one transfer unit for CH_SEL
- BUS_REQ  out  1  bus request to BSC
- CH_SEL  out  2  selected channel number
- CH_ACT  out  1  grant valid; datapath may run a unit for CH_SEL
- CH_ACK  out  4  one-hot, one-CE pulse per completed unit
- ARB_IDLE  out  1  state is IDLE

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE, BUS_REQ=0, CH_SEL=0, CH_ACT=0, CH_ACK=0, ARB_IDLE=1.
  - Round-robin pointer RR=0.
  - Applies immediately from any state, including mid-transfer.
- Enable: en = DME & ~NMIF & ~AE. Effective requests: REQ_E = CH_REQ & {4{en}}.
- Priority, evaluated combinationally on REQ_E:
  - PR=00: CH0>CH3>CH2>CH1.
  - PR=01: CH1>CH3>CH2>CH0.
  - PR=10: round robin. Order is RR, RR+1, RR+2, RR+3 (mod 4). On each XFER_DONE for channel n, RR <= (n+1) mod 4.
  - PR=11: reserved, treated as 00.
  - RR updates only in PR=10; it holds its value while PR!=10.
- States: IDLE, REQ, XFER.
- IDLE:
  - If REQ_E!=0: latch the winner into CH_SEL, set BUS_REQ=1, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - If CH_REQ[CH_SEL]=0 or en=0: BUS_REQ=0, go to IDLE (request withdrawn).
  - Else if BUS_GNT=1: CH_ACT=1, go to XFER.
  - CH_SEL is frozen in REQ; a higher-priority request arriving in REQ does not preempt.
- XFER:
  - Wait for XFER_DONE. A started unit always completes, even if en or CH_REQ drops.
  - On XFER_DONE: CH_ACK[CH_SEL]=1 for exactly that CE cycle.
  - Burst continue: if CH_TM[CH_SEL]=1 & CH_REQ[CH_SEL]=1 & en=1, stay in XFER with CH_ACT=1 and the same channel. Higher priority does not preempt a burst.
  - Otherwise: CH_ACT=0, BUS_REQ=0, go to IDLE. BUS_REQ is therefore low for at least one CE cycle between cycle-steal units, releasing the bus to the CPU.
- Latency:
  - Request to BUS_REQ: 1 CE cycle.
  - BUS_GNT to CH_ACT: 1 CE cycle.
  - Cycle-steal unit-to-unit minimum gap: 3 CE cycles (IDLE, REQ, XFER).
- Glitch-free outputs: CH_ACK is registered. BUS_REQ, CH_ACT and CH_SEL are registered and change only at CE edges.
- BUS_GNT deassertion during XFER is ignored; the BSC must not revoke a grant mid-unit.
- XFER_DONE outside XFER is ignored.
- ARB_IDLE = (state==IDLE).

Test Plan:
- Fixed priority: PR=00, DME=1, CH_REQ=4'b1110, CH_TM=0, BUS_GNT tied 1 → first CH_SEL=3, then 2, then 1 after each ack, with CH_ACK=1000, 0100, 0010 in sequence; BUS_REQ drops for 1 cycle between units.
- Round robin: PR=10, CH_REQ=4'b1111 held, 8 units → CH_SEL sequence 0,1,2,3,0,1,2,3 with RR wrapping 3→0.
- Burst: PR=00, CH_TM=4'b0001, CH_REQ[0]=1 for 4 units, CH_REQ[3]=1 throughout → BUS_REQ stays high across all 4 CH0 acks with no preemption; CH3 is granted only after CH_REQ[0] drops.
- Halt: set NMIF=1 while in XFER for CH2 → pending unit completes with CH_ACK=0100, then IDLE; no further BUS_REQ while NMIF=1; clearing NMIF resumes grants.
- Withdraw: CH_REQ[1] pulsed 1 cycle with BUS_GNT=0 → BUS_REQ rises, then falls once state is back in IDLE; no CH_ACT and no CH_ACK.
- Async reset asserted in XFER with CE=0 → all outputs return to reset values immediately; after release with PR=10, the first grant goes to CH0 (RR=0).
